// File: rtl/window_search_ctrl.sv
// Scan sequencer for the sliding-window SAD match engine: walks a WIN x WIN template
// over every frame position in raster order and keeps the minimum-SAD position.
module window_search_ctrl #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int WIN     = 4,
  parameter int AW      = 12,
  parameter int TW      = 4,
  parameter int SW      = 12,
  parameter int CW      = 6
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  output logic          Busy,
  output logic          Done,
  output logic          RdEn,
  output logic [AW-1:0] FrameAddr,
  output logic [TW-1:0] WinAddr,
  output logic          SadClr,
  input  logic          SadValid,
  input  logic [SW-1:0] SadIn,
  output logic [CW-1:0] BestRow,
  output logic [CW-1:0] BestCol,
  output logic [SW-1:0] BestSad
);

  localparam int XW = $clog2(FRAME_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] LAST_PIX = CW'(WIN - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(FRAME_H - WIN);
  localparam logic [CW-1:0] LAST_COL = CW'(FRAME_W - WIN);

  logic [2:0]    state, state_n;
  logic [CW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic [CW-1:0] pix_r, pix_r_n;
  logic [CW-1:0] pix_c, pix_c_n;
  logic          best_init;
  logic          best_load;
  logic          last_pix;
  logic          last_pos;
  logic [CW-1:0] abs_row;
  logic [CW-1:0] abs_col;
  logic [AW-1:0] frame_addr_n;
  logic [TW-1:0] win_addr_n;

  assign last_pix = (pix_r == LAST_PIX) && (pix_c == LAST_PIX);
  assign last_pos = (row == LAST_ROW) && (col == LAST_COL);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n   = state;
    row_n     = row;
    col_n     = col;
    pix_r_n   = pix_r;
    pix_c_n   = pix_c;
    best_init = 1'b0;
    best_load = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start) begin
          state_n   = S_CLEAR;
          row_n     = '0;
          col_n     = '0;
          best_init = 1'b1;
        end
      end

      S_CLEAR: begin
        state_n = S_READ;
        pix_r_n = '0;
        pix_c_n = '0;
      end

      S_READ: begin
        if (last_pix) begin
          state_n = S_WAIT;
        end else if (pix_c == LAST_PIX) begin
          pix_c_n = '0;
          pix_r_n = pix_r + 1'b1;
        end else begin
          pix_c_n = pix_c + 1'b1;
        end
      end

      S_WAIT: begin
        if (SadValid) begin
          // Strict compare so that ties keep the earlier raster position.
          best_load = (SadIn < BestSad);
          if (last_pos) begin
            state_n = S_DONE;
          end else begin
            state_n = S_CLEAR;
            if (col == LAST_COL) begin
              col_n = '0;
              row_n = row + 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Addresses for the cycle being entered; FRAME_W is a power of two so the row
  // simply lands above the column bits.
  assign abs_row      = row_n + pix_r_n;
  assign abs_col      = col_n + pix_c_n;
  assign frame_addr_n = (AW'(abs_row) << XW) | AW'(abs_col);
  assign win_addr_n   = TW'(32'(pix_r_n) * WIN + 32'(pix_c_n));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values and the block order does not matter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      pix_r     <= '0;
      pix_c     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      RdEn      <= 1'b0;
      SadClr    <= 1'b0;
      FrameAddr <= '0;
      WinAddr   <= '0;
    end else begin
      state  <= state_n;
      row    <= row_n;
      col    <= col_n;
      pix_r  <= pix_r_n;
      pix_c  <= pix_c_n;
      // Strobes are registered from the next state so they line up with that state.
      Busy   <= (state_n != S_IDLE);
      Done   <= (state_n == S_DONE);
      RdEn   <= (state_n == S_READ);
      SadClr <= (state_n == S_CLEAR);
      if (state_n == S_READ) begin
        FrameAddr <= frame_addr_n;
        WinAddr   <= win_addr_n;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      BestRow <= '0;
      BestCol <= '0;
      BestSad <= '1;
    end else if (best_init) begin
      BestRow <= '0;
      BestCol <= '0;
      BestSad <= '1;
    end else if (best_load) begin
      BestRow <= row;
      BestCol <= col;
      BestSad <= SadIn;
    end
  end

endmodule
